// File: rtl/mips_branch_predictor_pkg.sv
// Shared types for the MIPS branch predictor: counter encodings, mode selectors, BTB entry layout.
package mips_branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt2_e;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Tag field sized for the smallest legal BTB; unused upper bits stay zero.
  localparam int TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

endpackage

// File: rtl/mips_branch_predictor_sat_counter2.sv
// 2-bit saturating counter step: count up on taken, down on not-taken, clamp at SNT/ST.
module sat_counter2
  import mips_branch_predictor_pkg::*;
(
  input  cnt2_e cnt_i,
  input  logic  taken_i,
  output cnt2_e cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    case (cnt_i)
      SNT:     cnt_o = taken_i ? WNT : SNT;
      WNT:     cnt_o = taken_i ? WT  : SNT;
      WT:      cnt_o = taken_i ? ST  : WNT;
      ST:      cnt_o = taken_i ? ST  : WT;
      default: cnt_o = WNT;
    endcase
  end

endmodule

// File: rtl/mips_branch_predictor.sv
// PHT + direct-mapped BTB branch predictor with zero-latency IF lookup and EX-stage update.
module mips_branch_predictor
  import mips_branch_predictor_pkg::*;
#(
  parameter int PHT_BITS = 8,
  parameter int BTB_BITS = 6,
  parameter int GHR_BITS = 8,
  parameter int MODE     = 0,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         f_pc_i,
  output logic                f_pred_taken_o,
  output logic [31:0]         f_pred_target_o,
  output logic                f_btb_hit_o,
  input  logic                ex_valid_i,
  input  logic [31:0]         ex_pc_i,
  input  logic                ex_taken_i,
  input  logic [31:0]         ex_target_i,
  input  logic                ex_pred_taken_i,
  input  logic [31:0]         ex_pred_target_i,
  input  logic [PHT_BITS-1:0] ex_pht_idx_i,
  output logic                ex_mispredict_o,
  output logic [31:0]         ex_redirect_pc_o,
  output logic [CNT_W-1:0]    stat_branches_o,
  output logic [CNT_W-1:0]    stat_mispredicts_o
);

  localparam int PHT_N = 1 << PHT_BITS;
  localparam int BTB_N = 1 << BTB_BITS;

  logic [1:0]          pht_q [PHT_N];
  logic [1:0]          pht_d [PHT_N];
  btb_entry_t          btb_q [BTB_N];
  btb_entry_t          btb_d [BTB_N];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [CNT_W-1:0]    stat_br_q, stat_br_d;
  logic [CNT_W-1:0]    stat_mp_q, stat_mp_d;

  logic [PHT_BITS-1:0]  ghr_ext_s;
  logic [PHT_BITS-1:0]  f_pht_idx_s;
  logic [BTB_BITS-1:0]  f_btb_idx_s;
  logic [BTB_BITS-1:0]  ex_btb_idx_s;
  logic [TAG_MAX_W-1:0] f_tag_s;
  logic [TAG_MAX_W-1:0] ex_tag_s;
  btb_entry_t           f_entry_s;
  cnt2_e                pht_upd_s;

  assign ghr_ext_s    = PHT_BITS'(ghr_q);
  assign f_pht_idx_s  = f_pc_i[PHT_BITS+1:2] ^ ((MODE == MODE_GSHARE) ? ghr_ext_s : '0);
  assign f_btb_idx_s  = f_pc_i[BTB_BITS+1:2];
  assign ex_btb_idx_s = ex_pc_i[BTB_BITS+1:2];
  assign f_tag_s      = TAG_MAX_W'(f_pc_i >> (BTB_BITS + 2));
  assign ex_tag_s     = TAG_MAX_W'(ex_pc_i >> (BTB_BITS + 2));
  assign f_entry_s    = btb_q[f_btb_idx_s];

  // Lookup reads committed state only, so a same-cycle update is seen next cycle.
  assign f_btb_hit_o     = f_entry_s.valid && (f_entry_s.tag == f_tag_s);
  assign f_pred_taken_o  = f_btb_hit_o && pht_q[f_pht_idx_s][1];
  assign f_pred_target_o = f_btb_hit_o ? f_entry_s.target : f_pc_i + 32'd4;

  assign ex_mispredict_o  = ex_valid_i &&
                            ((ex_pred_taken_i != ex_taken_i) ||
                             (ex_taken_i && (ex_pred_target_i != ex_target_i)));
  assign ex_redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;

  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mp_q;

  sat_counter2 u_sat (
    .cnt_i   (cnt2_e'(pht_q[ex_pht_idx_i])),
    .taken_i (ex_taken_i),
    .cnt_o   (pht_upd_s)
  );

  always_comb begin
    pht_d     = pht_q;
    btb_d     = btb_q;
    ghr_d     = ghr_q;
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (ex_valid_i) begin
      pht_d[ex_pht_idx_i] = pht_upd_s;
      if (ex_taken_i) begin
        btb_d[ex_btb_idx_s] = '{valid: 1'b1, tag: ex_tag_s, target: ex_target_i};
      end else begin
        btb_d[ex_btb_idx_s] = btb_q[ex_btb_idx_s];
      end
      if (MODE == MODE_GSHARE) begin
        ghr_d = {ghr_q[GHR_BITS-2:0], ex_taken_i};
      end else begin
        ghr_d = ghr_q;
      end
      stat_br_d = (stat_br_q == '1) ? stat_br_q : stat_br_q + CNT_W'(1);
      stat_mp_d = (ex_mispredict_o && (stat_mp_q != '1)) ? stat_mp_q + CNT_W'(1) : stat_mp_q;
    end else begin
      stat_br_d = stat_br_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= WNT;
      for (int i = 0; i < BTB_N; i++) btb_q[i] <= '0;
      ghr_q     <= '0;
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      pht_q     <= pht_d;
      btb_q     <= btb_d;
      ghr_q     <= ghr_d;
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

endmodule
